// File: rtl/tick_sequencer.sv
// Armable count-enable sequencer: waits for a control-path rising edge, then emits
// divisor-spaced ticks until the latched budget is spent.

package pipeline_types;
   typedef struct packed {
      logic rising;
   } control_path_t;
endpackage

module tick_sequencer #(
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned ARM_TIMEOUT = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  pipeline_types::control_path_t i_control,
   input  logic                          i_start,
   input  logic                          i_abort,
   input  logic [DIV_W-1:0]              i_divisor,
   input  logic [CNT_W-1:0]              i_tick_budget,
   output logic                          o_tick,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_timeout,
   output logic [CNT_W-1:0]              o_tick_count
);

   localparam int unsigned TMR_W = $clog2(ARM_TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

   state_e             state_q;
   logic [DIV_W-1:0]   div_q;
   logic [CNT_W-1:0]   budget_q;
   logic [DIV_W-1:0]   pre_q;
   logic [TMR_W-1:0]   timer_q;
   logic               timed_out_q;
   logic               tick_q;
   logic               busy_q;
   logic               done_q;
   logic               timeout_q;
   logic [CNT_W-1:0]   count_q;

   logic [DIV_W-1:0]   div_last;
   logic [CNT_W-1:0]   cnt_inc;
   logic               div_one;
   logic               arm_expired;

   assign div_last    = div_q - 1'b1;
   assign cnt_inc     = count_q + 1'b1;
   assign div_one     = (div_q == DIV_W'(1));
   assign arm_expired = (timer_q == TMR_W'(ARM_TIMEOUT - 1));

   // pre_q holds the phase position of the current cycle; a rising edge defines
   // position 0 in its own cycle, so the register is loaded with position 1.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q     <= StIdle;
         div_q       <= '0;
         budget_q    <= '0;
         pre_q       <= '0;
         timer_q     <= '0;
         timed_out_q <= 1'b0;
         tick_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         tick_q <= 1'b0;
         done_q <= 1'b0;
         if (i_abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (i_start) begin
                     div_q       <= (i_divisor == '0) ? DIV_W'(1) : i_divisor;
                     budget_q    <= i_tick_budget;
                     count_q     <= '0;
                     timeout_q   <= 1'b0;
                     timed_out_q <= 1'b0;
                     timer_q     <= '0;
                     busy_q      <= 1'b1;
                     state_q     <= StArm;
                  end
               end
               StArm: begin
                  timer_q <= timer_q + 1'b1;
                  if (i_control.rising) begin
                     if (budget_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                     end else if (div_one) begin
                        pre_q   <= '0;
                        tick_q  <= 1'b1;
                        count_q <= cnt_inc;
                        if (cnt_inc == budget_q) begin
                           busy_q  <= 1'b0;
                           state_q <= StDone;
                        end else begin
                           state_q <= StRun;
                        end
                     end else begin
                        pre_q   <= DIV_W'(1);
                        state_q <= StRun;
                     end
                  end else if (arm_expired) begin
                     timed_out_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= StDone;
                  end
               end
               StRun: begin
                  if (i_control.rising) begin
                     pre_q <= div_one ? '0 : DIV_W'(1);
                  end else if (pre_q == div_last) begin
                     pre_q   <= '0;
                     tick_q  <= 1'b1;
                     count_q <= cnt_inc;
                     if (cnt_inc == budget_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                     end
                  end else begin
                     pre_q <= pre_q + 1'b1;
                  end
               end
               StDone: begin
                  done_q    <= 1'b1;
                  timeout_q <= timed_out_q;
                  state_q   <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign o_tick       = tick_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_timeout    = timeout_q;
   assign o_tick_count = count_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: directed scenarios plus random traffic, compared every
// cycle against a cycle-number-arithmetic model of the run controller.

module tb_tick_sequencer;

   localparam int unsigned DivW  = 16;
   localparam int unsigned CntW  = 8;
   localparam int unsigned ArmTo = 16;

   localparam int PhIdle = 0;
   localparam int PhArm  = 1;
   localparam int PhRun  = 2;
   localparam int PhDone = 3;

   logic                          i_clk = 1'b0;
   logic                          i_reset_n;
   pipeline_types::control_path_t i_control;
   logic                          i_start;
   logic                          i_abort;
   logic [DivW-1:0]               i_divisor;
   logic [CntW-1:0]               i_tick_budget;
   logic                          o_tick;
   logic                          o_busy;
   logic                          o_done;
   logic                          o_timeout;
   logic [CntW-1:0]               o_tick_count;

   always #5 i_clk = ~i_clk;

   tick_sequencer #(
      .DIV_W      (DivW),
      .CNT_W      (CntW),
      .ARM_TIMEOUT(ArmTo)
   ) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_control    (i_control),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_divisor    (i_divisor),
      .i_tick_budget(i_tick_budget),
      .o_tick       (o_tick),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_timeout    (o_timeout),
      .o_tick_count (o_tick_count)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int tick_log[$];
   int done_log[$];

   // Reference model: phase, latched config and the cycle of the last alignment edge.
   int m_phase = PhIdle;
   int m_d, m_b, m_align, m_arm_enter, m_tflag;
   int m_tick, m_busy, m_done, m_timeout, m_count;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
   endtask

   // A tick lands in cycle c+1 when c+1 is a whole number of periods after alignment.
   task automatic model_tick(input int c);
      if (((c + 1 - m_align) % m_d) == 0) begin
         m_tick  = 1;
         m_count = m_count + 1;
         if (m_count == m_b) begin
            m_phase = PhDone;
            m_busy  = 0;
         end
      end
   endtask

   task automatic model_step();
      int c;
      c      = cyc;
      m_tick = 0;
      m_done = 0;
      if (!i_reset_n) begin
         m_phase = PhIdle; m_busy = 0; m_timeout = 0; m_count = 0; m_tflag = 0;
      end else if (i_abort) begin
         m_phase = PhIdle;
         m_busy  = 0;
      end else begin
         case (m_phase)
            PhIdle: if (i_start) begin
               m_d         = (i_divisor == 0) ? 1 : int'(i_divisor);
               m_b         = int'(i_tick_budget);
               m_count     = 0;
               m_timeout   = 0;
               m_tflag     = 0;
               m_busy      = 1;
               m_arm_enter = c + 1;
               m_phase     = PhArm;
            end
            PhArm: if (i_control.rising) begin
               m_align = c;
               if (m_b == 0) begin
                  m_phase = PhDone;
                  m_busy  = 0;
               end else begin
                  m_phase = PhRun;
                  model_tick(c);
               end
            end else if (c - m_arm_enter + 1 == int'(ArmTo)) begin
               m_tflag = 1;
               m_phase = PhDone;
               m_busy  = 0;
            end
            PhRun: if (i_control.rising) m_align = c;
                   else model_tick(c);
            default: begin
               m_done    = 1;
               m_timeout = m_tflag;
               m_phase   = PhIdle;
            end
         endcase
      end
   endtask

   task automatic step(input logic st, input logic ab, input logic ri, input logic [DivW-1:0] dv,
                       input logic [CntW-1:0] bg, input logic rn);
      i_start          = st;
      i_abort          = ab;
      i_control.rising = ri;
      i_divisor        = dv;
      i_tick_budget    = bg;
      i_reset_n        = rn;
      @(posedge i_clk);
      model_step();
      cyc++;
      #1;
      check_val("tick",    32'(o_tick),       32'(m_tick));
      check_val("busy",    32'(o_busy),       32'(m_busy));
      check_val("done",    32'(o_done),       32'(m_done));
      check_val("timeout", 32'(o_timeout),    32'(m_timeout));
      check_val("count",   32'(o_tick_count), 32'(m_count));
      if (o_tick) tick_log.push_back(cyc);
      if (o_done) done_log.push_back(cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic rise();
      step(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
   endtask

   task automatic start(input int dv, input int bg);
      step(1'b1, 1'b0, 1'b0, DivW'(dv), CntW'(bg), 1'b1);
   endtask

   function automatic int tick_off(input int k, input int base);
      if (k < tick_log.size()) return tick_log[k] - base;
      return -1;
   endfunction

   function automatic int done_off(input int base);
      if (done_log.size() > 0) return done_log[0] - base;
      return -1;
   endfunction

   task automatic clear_logs();
      tick_log.delete();
      done_log.delete();
   endtask

   initial begin
      int n;
      int s;
      i_control = '0;
      // Reset state
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'd3, 8'd3, 1'b0);
      idle(2);

      // Basic run: D=5, B=3, rising 4 cycles after start
      clear_logs();
      start(5, 3); idle(3); n = cyc; rise(); idle(20);
      check_val("basic_t1",   tick_off(0, n), 5);
      check_val("basic_t2",   tick_off(1, n), 10);
      check_val("basic_t3",   tick_off(2, n), 15);
      check_val("basic_nt",   tick_log.size(), 3);
      check_val("basic_done", done_off(n), 16);

      // Re-align: second rising at N+8
      clear_logs();
      start(5, 4); idle(2); n = cyc; rise(); idle(7); rise(); idle(20);
      check_val("realign_t1", tick_off(0, n), 5);
      check_val("realign_t2", tick_off(1, n), 13);
      check_val("realign_t3", tick_off(2, n), 18);
      check_val("realign_t4", tick_off(3, n), 23);

      // Rising exactly on the wrap cycle suppresses that tick
      clear_logs();
      start(5, 2); idle(1); n = cyc; rise(); idle(3); rise(); idle(14);
      check_val("simul_t1", tick_off(0, n), 9);
      check_val("simul_t2", tick_off(1, n), 14);

      // ARM timeout, then a fresh start clears o_timeout
      clear_logs();
      s = cyc; start(3, 3); idle(24);
      check_val("to_done", done_off(s), int'(ArmTo) + 2);
      check_val("to_flag", 32'(o_timeout), 1);
      start(3, 3);
      check_val("to_clear", 32'(o_timeout), 0);
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
      idle(2);

      // Abort after three ticks, with a start pulse ignored mid-run
      clear_logs();
      start(2, 10); n = cyc; rise(); idle(2);
      step(1'b1, 1'b0, 1'b0, 16'd7, 8'd1, 1'b1);
      idle(2);
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
      check_val("abort_cnt",  32'(o_tick_count), 3);
      check_val("abort_busy", 32'(o_busy), 0);
      idle(6);
      check_val("abort_nt",   tick_log.size(), 3);
      check_val("abort_nd",   done_log.size(), 0);

      // Divisor 0 behaves as 1
      clear_logs();
      start(0, 2); idle(1); n = cyc; rise(); idle(5);
      check_val("div0_t1", tick_off(0, n), 1);
      check_val("div0_t2", tick_off(1, n), 2);
      check_val("div0_done", done_off(n), 3);

      // Zero budget
      clear_logs();
      start(3, 0); idle(2); n = cyc; rise(); idle(5);
      check_val("b0_nt",   tick_log.size(), 0);
      check_val("b0_done", done_off(n), 2);

      // Reset mid-run
      start(3, 50); rise(); idle(7);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      check_val("rst_busy", 32'(o_busy), 0);
      check_val("rst_cnt",  32'(o_tick_count), 0);
      idle(3);

      // Random traffic
      for (int k = 0; k < 4000; k++) begin
         logic st, ab, ri, rn;
         logic [DivW-1:0] dv;
         logic [CntW-1:0] bg;
         st = ($urandom_range(0, 5) == 0);
         ab = ($urandom_range(0, 79) == 0);
         ri = ($urandom_range(0, 11) == 0);
         rn = ($urandom_range(0, 599) != 0);
         dv = ($urandom_range(0, 9) == 0) ? DivW'($urandom_range(0, 40))
                                          : DivW'($urandom_range(0, 4));
         bg = CntW'($urandom_range(0, 6));
         step(st, ab, ri, dv, bg, rn);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
